// File: rtl/qif_neuron_scheduler.sv
// -----------------------------------------------------------------------------
// qif_neuron_scheduler
//
// Time-multiplexes one shared QIF neuron update core across N_NEURONS virtual
// neurons. Per-neuron membrane and bias values live here; each timestep sweep
// issues every neuron to the core once, in ascending index order, and writes the
// returned membrane back CORE_LAT cycles later. Neurons that spike have their
// membrane returned to V_RESET and their index queued in a small event FIFO.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   step_start               pulse: begin one sweep (ignored unless idle)
//   busy, step_done          sweep in progress / 1-cycle completion pulse
//   step_count[15:0]         completed sweeps, wrapping
//   cfg_we/cfg_idx/cfg_bias  bias register write port
//   core_valid/idx/v/b       issue port to the shared core (registered)
//   core_v_next/core_spike   core result, sampled CORE_LAT cycles after issue
//   ev_valid/ev_idx/ev_ready spike event FIFO head, valid/ready handshake
//   overflow, ov_clr         sticky "event dropped" flag and its clear
// -----------------------------------------------------------------------------
module qif_neuron_scheduler #(
  parameter int N_NEURONS  = 8,
  parameter int IDX_W      = 3,
  parameter int DATA_W     = 8,
  parameter int CORE_LAT   = 1,
  parameter int FIFO_DEPTH = 4,  // power of two, >= 2
  parameter int V_RESET    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_start,
  output logic              busy,
  output logic              step_done,
  output logic [15:0]       step_count,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [DATA_W-1:0] cfg_bias,
  output logic              core_valid,
  output logic [IDX_W-1:0]  core_idx,
  output logic [DATA_W-1:0] core_v,
  output logic [DATA_W-1:0] core_b,
  input  logic [DATA_W-1:0] core_v_next,
  input  logic              core_spike,
  output logic              ev_valid,
  output logic [IDX_W-1:0]  ev_idx,
  input  logic              ev_ready,
  output logic              overflow,
  input  logic              ov_clr
);

  localparam int                FP_W     = $clog2(FIFO_DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_NEURONS - 1);
  localparam logic [DATA_W-1:0] V_RST    = DATA_W'(V_RESET);
  localparam logic [FP_W:0]     CNT_FULL = (FP_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                core_valid_q, core_valid_d;
  logic [IDX_W-1:0]    core_idx_q, core_idx_d;
  logic [DATA_W-1:0]   core_v_q, core_v_d;
  logic [DATA_W-1:0]   core_b_q, core_b_d;
  logic [15:0]         step_count_q, step_count_d;

  logic [DATA_W-1:0]   mem_q  [N_NEURONS];
  logic [DATA_W-1:0]   mem_d  [N_NEURONS];
  logic [DATA_W-1:0]   bias_q [N_NEURONS];
  logic [DATA_W-1:0]   bias_d [N_NEURONS];

  // Result pipeline: stage k holds an issue made k+1 cycles ago.
  logic [CORE_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [IDX_W-1:0]    pipe_idx_q [CORE_LAT];
  logic [IDX_W-1:0]    pipe_idx_d [CORE_LAT];

  logic [IDX_W-1:0]    fifo_q [FIFO_DEPTH];
  logic [IDX_W-1:0]    fifo_d [FIFO_DEPTH];
  logic [FP_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [FP_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FP_W:0]       cnt_q, cnt_d;
  logic                overflow_q, overflow_d;

  logic                samp_vld;
  logic [IDX_W-1:0]    samp_idx;
  logic                push_req, push_ok, pop, full;

  assign samp_vld = pipe_vld_q[CORE_LAT-1];
  assign samp_idx = pipe_idx_q[CORE_LAT-1];

  // ---------------------------------------------------------------------------
  // Sweep FSM and issue port
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; an unassigned path in always_comb would infer a latch.
    state_d      = state_q;
    core_valid_d = 1'b0;
    core_idx_d   = core_idx_q;
    core_v_d     = core_v_q;
    core_b_d     = core_b_q;
    step_count_d = step_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (step_start) begin
          state_d      = S_ISSUE;
          core_valid_d = 1'b1;
          core_idx_d   = '0;
        end
      end
      S_ISSUE: begin
        if (core_idx_q == LAST_IDX) begin
          state_d = S_DRAIN;
        end else begin
          core_valid_d = 1'b1;
          core_idx_d   = core_idx_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // The last neuron issued is the last one written back.
        if (samp_vld && samp_idx == LAST_IDX) begin
          state_d      = S_DONE;
          step_count_d = step_count_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Every neuron is issued once per sweep, so the stored membrane read here is
    // never the target of a writeback still in flight.
    if (core_valid_d) begin
      core_v_d = mem_q[core_idx_d];
      core_b_d = bias_q[core_idx_d];
    end
  end

  // ---------------------------------------------------------------------------
  // Result pipeline, membrane writeback and bias writes
  // ---------------------------------------------------------------------------
  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_idx_d    = pipe_idx_q;
    pipe_vld_d[0] = core_valid_q;
    pipe_idx_d[0] = core_idx_q;
    for (int k = 1; k < CORE_LAT; k++) begin
      pipe_vld_d[k] = pipe_vld_q[k-1];
      pipe_idx_d[k] = pipe_idx_q[k-1];
    end

    mem_d = mem_q;
    if (samp_vld) begin
      mem_d[samp_idx] = core_spike ? V_RST : core_v_next;
    end

    // The issue register was loaded a cycle earlier, so a write to the neuron
    // currently on the issue port only takes effect on the next sweep.
    bias_d = bias_q;
    if (cfg_we) begin
      bias_d[cfg_idx] = cfg_bias;
    end
  end

  // ---------------------------------------------------------------------------
  // Spike event FIFO
  // ---------------------------------------------------------------------------
  always_comb begin
    push_req = samp_vld && core_spike;
    pop      = (cnt_q != '0) && ev_ready;
    full     = (cnt_q == CNT_FULL);
    // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
    push_ok  = push_req && (!full || pop);

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      fifo_d[wr_ptr_q] = samp_idx;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    // A drop in the same cycle as a clear wins, so no lost event goes unreported.
    overflow_d = overflow_q;
    if (ov_clr) begin
      overflow_d = 1'b0;
    end
    if (push_req && !push_ok) begin
      overflow_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= S_IDLE;
      core_valid_q <= 1'b0;
      core_idx_q   <= '0;
      core_v_q     <= '0;
      core_b_q     <= '0;
      step_count_q <= '0;
      pipe_vld_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      overflow_q   <= 1'b0;
      // NOTE: membrane and bias arrays are architectural state that must come up
      // at known values, so they are reset; FIFO storage is not, because it is
      // only ever read behind the occupancy count.
      for (int i = 0; i < N_NEURONS; i++) begin
        mem_q[i]  <= V_RST;
        bias_q[i] <= '0;
      end
      for (int k = 0; k < CORE_LAT; k++) begin
        pipe_idx_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      core_valid_q <= core_valid_d;
      core_idx_q   <= core_idx_d;
      core_v_q     <= core_v_d;
      core_b_q     <= core_b_d;
      step_count_q <= step_count_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_idx_q   <= pipe_idx_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      overflow_q   <= overflow_d;
      mem_q        <= mem_d;
      bias_q       <= bias_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy       = (state_q != S_IDLE);
  assign step_done  = (state_q == S_DONE);
  assign step_count = step_count_q;
  assign core_valid = core_valid_q;
  assign core_idx   = core_idx_q;
  assign core_v     = core_v_q;
  assign core_b     = core_b_q;
  assign ev_valid   = (cnt_q != '0);
  assign ev_idx     = fifo_q[rd_ptr_q];
  assign overflow   = overflow_q;

endmodule
